uart_rx_frame_ctrl: RTL

//  UART receive frame controller: detects start bit, runs oversampling edge/bit counters, enables the
//  3-point majority sampler (data_sampling) and consumes its sampled_bit. Deserializes LSB-first data,

---
 rtl/uart_rx_frame_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, oversampling edge/bit counters,
// LSB-first deserialization, optional parity and stop-bit checking with 1-cycle result strobes.
module uart_rx_frame_ctrl #(
    parameter  int PRESCALE   = 16,
    parameter  int DATA_WIDTH = 8,
    localparam int EW         = $clog2(PRESCALE),
    localparam int BW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [EW-1:0]         edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    // Expected parity bit for a data word: even parity when odd_sel is 0, odd when 1.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd_sel);
        calc_parity = (^data) ^ odd_sel;
    endfunction

    state_t                state_q, state_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [5:0]            presc_q, presc_d;
    logic                  pen_q, pen_d;
    logic                  ptyp_q, ptyp_d;
    logic                  par_flag_q, par_flag_d;
    logic                  samp_en_q, samp_en_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  sg_q, sg_d;
    logic [5:0]            presc_m1_s;
    logic                  end_bit_s;

    // Last oversample slot of the current bit, using the ratio latched at frame start.
    always_comb begin
        presc_m1_s = presc_q - 6'd1;
        end_bit_s  = (edge_q == EW'(presc_m1_s));
    end

    // Next-state, counter and strobe logic.
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pdata_d    = pdata_q;
        presc_d    = presc_q;
        pen_d      = pen_q;
        ptyp_d     = ptyp_q;
        par_flag_d = par_flag_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        sg_d       = 1'b0;

        if (state_q == IDLE) begin
            edge_d = '0;
        end else if (end_bit_s) begin
            edge_d = '0;
        end else begin
            edge_d = edge_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    presc_d    = Prescale;
                    pen_d      = PAR_EN;
                    ptyp_d     = PAR_TYP;
                    par_flag_d = 1'b0;
                    bit_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (end_bit_s) begin
                    if (sampled_bit) begin
                        sg_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (end_bit_s) begin
                    // Line order is LSB first, so each new bit enters at the top.
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (end_bit_s) begin
                    par_flag_d = (sampled_bit != calc_parity(shift_q, ptyp_q));
                    state_d    = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (end_bit_s) begin
                    state_d = IDLE;
                    if (!sampled_bit) begin
                        se_d = 1'b1;
                    end else if (par_flag_q) begin
                        pe_d = 1'b1;
                    end else begin
                        dv_d    = 1'b1;
                        pdata_d = shift_q;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
            end
        endcase

        samp_en_d = (state_d != IDLE);
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pdata_q    <= '0;
            presc_q    <= 6'd0;
            pen_q      <= 1'b0;
            ptyp_q     <= 1'b0;
            par_flag_q <= 1'b0;
            samp_en_q  <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            sg_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            pdata_q    <= pdata_d;
            presc_q    <= presc_d;
            pen_q      <= pen_d;
            ptyp_q     <= ptyp_d;
            par_flag_q <= par_flag_d;
            samp_en_q  <= samp_en_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            sg_q       <= sg_d;
        end
    end

    assign data_samp_en = samp_en_q;
    assign edge_cnt     = edge_q;
    assign P_DATA       = pdata_q;
    assign data_valid   = dv_q;
    assign par_err      = pe_q;
    assign stp_err      = se_q;
    assign strt_glitch  = sg_q;

endmodule
